// File: rtl/mdu_iter_pkg.sv
// Shared definitions for the iterative multiply/divide unit (mdu_iter).
// Holds the op encodings, FSM state encodings and the iteration count.
package mdu_iter_pkg;

  localparam int MDU_ITER = 32;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } mdu_op_t;

  // FSM state encodings, kept as plain constants so the state register
  // stays a simple vector.
  typedef logic [1:0] mdu_state_t;
  localparam mdu_state_t ST_IDLE = 2'd0;
  localparam mdu_state_t ST_RUN  = 2'd1;
  localparam mdu_state_t ST_FIX  = 2'd2;

  // Magnitude of a 32-bit operand; 0x80000000 maps to itself, which is
  // the correct unsigned magnitude.
  function automatic logic [31:0] mag32(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/mdu_iter_divstep.sv
// One restoring-division step: shift the next dividend bit into the
// partial remainder, subtract the divisor if it fits, shift in the
// quotient bit.
module mdu_iter_divstep
  import mdu_iter_pkg::*;
(
  input  logic [31:0] rem_i,
  input  logic [31:0] quot_i,
  input  logic [31:0] divisor_i,
  output logic [31:0] rem_o,
  output logic [31:0] quot_o
);

  logic [32:0] shifted;
  logic [32:0] diff;
  logic        fits;

  // The partial remainder is always below the divisor, so the shifted
  // value is below twice the divisor and bit 32 of the difference is a
  // clean borrow flag. With a zero divisor the result is discarded.
  always_comb begin
    shifted = {rem_i, quot_i[31]};
    diff    = shifted - {1'b0, divisor_i};
    fits    = ~diff[32];
    rem_o   = fits ? diff[31:0] : shifted[31:0];
    quot_o  = {quot_i[30:0], fits};
  end

endmodule

// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit with HI/LO registers for the E stage.
// Raises stall_req while busy and the pipeline wants the MDU or HI/LO.
// Build option: define MDU_FAST_MUL_EN for a single-cycle registered
// multiplier (MULT/MULTU finish in two cycles); DIV stays iterative.
//
// state    | meaning
// ---------+---------------------------------------------------------
// ST_IDLE  | waiting; MUL/DIV start here, MTHI/MTLO complete here
// ST_RUN   | one shift-add or restoring-subtract step per cycle
// ST_FIX   | signed result presented on hi/lo, done high, commit
module mdu_iter
  import mdu_iter_pkg::*;
#(
  parameter int ITER  = MDU_ITER,
  parameter int CNT_W = 6
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  input  logic [2:0]  req_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        rd_hilo,
  input  logic        flush,
  output logic        busy,
  output logic        stall_req,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  mdu_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             is_div_q, is_div_d;
  logic             neg_q, neg_d;      // negate product / quotient
  logic             rneg_q, rneg_d;    // negate remainder
  logic             dz_q, dz_d;        // divide by zero
  logic [31:0]      a_q, a_d;          // original dividend for div-by-zero
  logic [31:0]      opnd_q, opnd_d;    // multiplicand or divisor magnitude
  logic [31:0]      acc_q, acc_d;      // product high half / remainder
  logic [31:0]      quo_q, quo_d;      // multiplier / quotient shift reg
  logic [31:0]      res_hi_q, res_hi_d;
  logic [31:0]      res_lo_q, res_lo_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;

  logic        accept, op_signed, a_neg, b_neg, last_step, show_res;
  logic [32:0] mul_sum;
  logic [31:0] mul_acc_n, mul_quo_n;
  logic [31:0] div_rem_n, div_quo_n;
  logic [63:0] prod_mag, prod_s;
  logic [31:0] quot_s, rem_s, fin_hi, fin_lo;

  mdu_iter_divstep u_divstep (
    .rem_i     (acc_q),
    .quot_i    (quo_q),
    .divisor_i (opnd_q),
    .rem_o     (div_rem_n),
    .quot_o    (div_quo_n)
  );

  // Shift-add multiply step and the final signed results.
  always_comb begin
    mul_sum   = {1'b0, acc_q} + {1'b0, (quo_q[0] ? opnd_q : 32'd0)};
    mul_acc_n = mul_sum[32:1];
    mul_quo_n = {mul_sum[0], quo_q[31:1]};
`ifdef MDU_FAST_MUL_EN
    prod_mag  = 64'(opnd_q) * 64'(quo_q);
    last_step = is_div_q ? (cnt_q == CNT_W'(ITER - 1)) : 1'b1;
`else
    prod_mag  = {mul_acc_n, mul_quo_n};
    last_step = (cnt_q == CNT_W'(ITER - 1));
`endif
    prod_s = neg_q  ? (~prod_mag + 64'd1) : prod_mag;
    quot_s = neg_q  ? (~div_quo_n + 32'd1) : div_quo_n;
    rem_s  = rneg_q ? (~div_rem_n + 32'd1) : div_rem_n;
    if (is_div_q) begin
      fin_hi = dz_q ? a_q : rem_s;
      fin_lo = dz_q ? 32'hFFFF_FFFF : quot_s;
    end else begin
      fin_hi = prod_s[63:32];
      fin_lo = prod_s[31:0];
    end
  end

  // Request decode and next-state logic.
  always_comb begin
    accept    = (state_q == ST_IDLE) && req_valid && !flush;
    op_signed = ~req_op[0];
    a_neg     = op_signed & a[31];
    b_neg     = op_signed & b[31];

    state_d  = state_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    dz_d     = dz_q;
    a_d      = a_q;
    opnd_d   = opnd_q;
    acc_d    = acc_q;
    quo_d    = quo_q;
    res_hi_d = res_hi_q;
    res_lo_d = res_lo_q;
    hi_d     = hi_q;
    lo_d     = lo_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (!req_op[2]) begin
            state_d  = ST_RUN;
            cnt_d    = '0;
            is_div_d = req_op[1];
            neg_d    = a_neg ^ b_neg;
            rneg_d   = a_neg;
            dz_d     = (b == 32'd0);
            a_d      = a;
            acc_d    = 32'd0;
            opnd_d   = req_op[1] ? mag32(b, op_signed) : mag32(a, op_signed);
            quo_d    = req_op[1] ? mag32(a, op_signed) : mag32(b, op_signed);
          end else if (req_op == OP_MTHI) begin
            hi_d = a;
          end else if (req_op == OP_MTLO) begin
            lo_d = a;
          end
        end
      end
      ST_RUN: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else begin
          acc_d = is_div_q ? div_rem_n : mul_acc_n;
          quo_d = is_div_q ? div_quo_n : mul_quo_n;
          cnt_d = cnt_q + CNT_W'(1);
          if (last_step) begin
            res_hi_d = fin_hi;
            res_lo_d = fin_lo;
            state_d  = ST_FIX;
          end
        end
      end
      ST_FIX: begin
        state_d = ST_IDLE;
        if (!flush) begin
          hi_d = res_hi_q;
          lo_d = res_lo_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      dz_q     <= 1'b0;
      a_q      <= 32'd0;
      opnd_q   <= 32'd0;
      acc_q    <= 32'd0;
      quo_q    <= 32'd0;
      res_hi_q <= 32'd0;
      res_lo_q <= 32'd0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      dz_q     <= dz_d;
      a_q      <= a_d;
      opnd_q   <= opnd_d;
      acc_q    <= acc_d;
      quo_q    <= quo_d;
      res_hi_q <= res_hi_d;
      res_lo_q <= res_lo_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  // Outputs: in FIX the result is forwarded so hi/lo are valid in the
  // done cycle; a flush in FIX drops both the result and done.
  always_comb begin
    busy      = (state_q != ST_IDLE);
    stall_req = busy && (req_valid || rd_hilo);
    show_res  = (state_q == ST_FIX) && !flush;
    done      = show_res;
    hi        = show_res ? res_hi_q : hi_q;
    lo        = show_res ? res_lo_q : lo_q;
  end

endmodule

// File: tb/tb_mdu_iter.sv
// Scoreboard bench for mdu_iter: each MUL/DIV request pushes its expected
// hi/lo and done cycle; a monitor pops and compares on every done pulse.
`timescale 1ns/1ps
module tb_mdu_iter;

`ifdef MDU_FAST_MUL_EN
  localparam int MUL_LAT = 2;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam int DIV_LAT = 33;

  logic        clk = 1'b0;
  logic        resetn;
  logic        req_valid;
  logic [2:0]  req_op;
  logic [31:0] a, b;
  logic        rd_hilo;
  logic        flush;
  logic        busy, stall_req, done;
  logic [31:0] hi, lo;

  always #5 clk = ~clk;

  mdu_iter dut (
    .clk       (clk),
    .resetn    (resetn),
    .req_valid (req_valid),
    .req_op    (req_op),
    .a         (a),
    .b         (b),
    .rd_hilo   (rd_hilo),
    .flush     (flush),
    .busy      (busy),
    .stall_req (stall_req),
    .done      (done),
    .hi        (hi),
    .lo        (lo)
  );

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (resetn === 1'b1 && done === 1'b1) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: done at cycle %0d with no request outstanding", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk({e.name, "_hi"}, hi, e.hi);
        chk({e.name, "_lo"}, lo, e.lo);
        chk({e.name, "_done_cycle"}, cyc, e.cyc);
      end
    end
  end

  // Present one request for one cycle; lat=0 means no done is expected.
  task automatic issue(input logic [2:0] op, input logic [31:0] av, input logic [31:0] bv,
                       input logic [31:0] ehi, input logic [31:0] elo, input int lat,
                       input string name);
    exp_t e;
    @(posedge clk); #1;
    req_valid = 1'b1; req_op = op; a = av; b = bv;
    if (lat > 0) begin
      e.hi = ehi; e.lo = elo; e.cyc = cyc + lat; e.name = name;
      sb.push_back(e);
    end
    @(negedge clk);
    chk({name, "_idle_stall"}, stall_req, 0);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  // Count busy cycles until the unit returns to idle (bounded).
  task automatic wait_idle(input string name, input int exp_busy);
    int n = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!busy) break;
      n++;
    end
    chk({name, "_busy_cycles"}, n, exp_busy);
  endtask

  task automatic run_op(input logic [2:0] op, input logic [31:0] av, input logic [31:0] bv,
                        input logic [31:0] ehi, input logic [31:0] elo, input int lat,
                        input string name);
    issue(op, av, bv, ehi, elo, lat, name);
    wait_idle(name, lat);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    resetn = 1'b0; req_valid = 1'b0; req_op = 3'd0; a = '0; b = '0;
    rd_hilo = 1'b0; flush = 1'b0;
    #12;
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    @(negedge clk); resetn = 1'b1;
    @(negedge clk);
    chk("post_rst_stall", stall_req, 0);

    run_op(3'd0, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, MUL_LAT, "mult_m2x3");
    run_op(3'd3, 32'd100, 32'd7, 32'd2, 32'd14, DIV_LAT, "divu_100_7");
    run_op(3'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, DIV_LAT, "div_m7_2");
    run_op(3'd2, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, DIV_LAT, "div_7_m2");
    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, DIV_LAT, "div_ovf");
    run_op(3'd3, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, DIV_LAT, "divu_by0");
    run_op(3'd2, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, DIV_LAT, "div_by0");
    run_op(3'd3, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'hFFFF_FFFF, DIV_LAT, "divu_max_1");
    run_op(3'd0, 32'd6, 32'd7, 32'd0, 32'd42, MUL_LAT, "mult_6x7");
    run_op(3'd0, 32'h8000_0000, 32'd2, 32'hFFFF_FFFF, 32'd0, MUL_LAT, "mult_min_x2");
    run_op(3'd1, 32'h1234_5678, 32'h10, 32'd1, 32'h2345_6780, MUL_LAT, "multu_shift");

    // MULTU with an MFHI/MFLO waiting behind it: stalls through done.
    issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1, MUL_LAT, "multu_max");
    rd_hilo = 1'b1;
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!stall_req) break;
      n++;
    end
    chk("rdhilo_stall_cycles", n, MUL_LAT);
    chk("rdhilo_busy_after", busy, 0);
    @(posedge clk); #1; rd_hilo = 1'b0;

    run_op(3'd4, 32'hABCD_0000, 32'd0, 32'd0, 32'd0, 0, "mthi");
    chk("mthi_hi", hi, 32'hABCD_0000);
    chk("mthi_lo_kept", lo, 32'd1);

    // DIV aborted by flush ten cycles in: no done, HI/LO untouched.
    issue(3'd3, 32'd100, 32'd7, 32'd0, 32'd0, 0, "div_flushed");
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(negedge clk);
    chk("flush_done", done, 0);
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    chk("flush_busy", busy, 0);
    chk("flush_hi_kept", hi, 32'hABCD_0000);
    chk("flush_lo_kept", lo, 32'd1);
    run_op(3'd5, 32'h1234, 32'd0, 32'd0, 32'd0, 0, "mtlo");
    chk("mtlo_lo", lo, 32'h1234);
    chk("mtlo_hi_kept", hi, 32'hABCD_0000);

    // Flush in IDLE suppresses acceptance of any op.
    @(posedge clk); #1;
    req_valid = 1'b1; req_op = 3'd4; a = 32'hDEAD_BEEF; flush = 1'b1;
    @(posedge clk); #1;
    req_op = 3'd0; a = 32'd3; b = 32'd3;
    @(negedge clk);
    chk("flush_mthi_hi", hi, 32'hABCD_0000);
    @(posedge clk); #1;
    req_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    chk("flush_mult_busy", busy, 0);

    // Asynchronous reset in the middle of a DIV.
    issue(3'd2, 32'd1000, 32'd3, 32'd0, 32'd0, 0, "div_reset");
    repeat (5) @(posedge clk);
    #3 resetn = 1'b0;
    #1;
    chk("arst_hi", hi, 0);
    chk("arst_lo", lo, 0);
    chk("arst_busy", busy, 0);
    @(negedge clk); resetn = 1'b1;

    run_op(3'd1, 32'd3, 32'd5, 32'd0, 32'd15, MUL_LAT, "multu_after_rst");

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
